// File: rtl/aes_pkg.sv
// Shared AES byte-substitution constants: FIPS-197 S-box tables, state geometry,
// substitution mode and the column-major byte-to-bit-slice mapping.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic {AES_FWD = 1'b0, AES_INV = 1'b1} aes_mode_e;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} sb_fsm_e;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Byte 0 (s[0][0]) sits in the top bits of the state word.
  function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
    return 7'(AES_STATE_W - 8) - {idx, 3'b000};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational single-byte S-box lookup; the inverse table is only built when INV_EN=1,
// otherwise the inv select is ignored and the forward table is always used.
module aes_sbox
  import aes_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  if (INV_EN) begin : g_inv
    assign dout = inv ? SBOX_INV[din] : SBOX_FWD[din];
  end else begin : g_fwd
    logic w_unused_inv;
    assign w_unused_inv = inv;
    assign dout         = SBOX_FWD[din];
  end

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential SubBytes/InvSubBytes, LANES bytes per cycle: result valid 16/LANES cycles after
// accept; output held until outReady, and a new state may be accepted on the draining cycle.
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES  = 4,
  parameter bit INV_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic                   inMode,
  input  logic [AES_STATE_W-1:0] prevState,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [AES_STATE_W-1:0] nextState,
  output logic                   busy
);

  localparam int BEATS = AES_BYTES / LANES;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  sb_fsm_e                r_state;
  sb_fsm_e                w_state_nxt;
  logic [3:0]             r_cnt;
  logic [AES_STATE_W-1:0] r_work;
  logic [AES_STATE_W-1:0] w_work_nxt;
  aes_mode_e              r_mode;
  logic                   w_accept;
  logic                   w_inv;
  logic [7:0]             w_sb_in  [LANES];
  logic [7:0]             w_sb_out [LANES];

  assign w_accept  = inValid && inReady;
  assign w_inv     = (r_mode == AES_INV);
  assign nextState = r_work;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (inValid)                 w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == 4'(BEATS - 1)) w_state_nxt = ST_DONE;
      ST_DONE: if (outReady)                w_state_nxt = inValid ? ST_RUN : ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    inReady  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && outReady);
    outValid = (r_state == ST_DONE);
    busy     = (r_state != ST_IDLE);
  end

  // Lane l of beat cnt works on byte cnt*LANES + l.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_sb_in[l] = r_work[byte_lsb(4'(int'(r_cnt) * LANES + l)) +: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox #(.INV_EN(INV_EN)) u_sbox (
      .din  (w_sb_in[l]),
      .inv  (w_inv),
      .dout (w_sb_out[l])
    );
  end

  always_comb begin
    w_work_nxt = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_work_nxt[byte_lsb(4'(int'(r_cnt) * LANES + l)) +: 8] = w_sb_out[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_work <= '0;
      r_mode <= AES_FWD;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_work <= prevState;
      r_mode <= (INV_EN && inMode) ? AES_INV : AES_FWD;
    end else if (r_state == ST_RUN) begin
      r_work <= w_work_nxt;
      r_cnt  <= (r_cnt == 4'(BEATS - 1)) ? 4'd0 : r_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: five configurations side by side, each checked every cycle against a
// transaction model whose S-boxes are derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_seq;

  localparam int ND = 5;
  localparam int LN [ND] = '{4, 16, 2, 1, 8};
  localparam bit IE [ND] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  localparam logic [127:0] T1_IN    = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] T1_OUT   = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] CORN_IN  = 128'h0020537dff0020537dff0020537dff00;
  localparam logic [127:0] CORN_OUT = 128'h63b7edff1663b7edff1663b7edff1663;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         inValid   [ND];
  logic         inReady   [ND];
  logic         inMode    [ND];
  logic [127:0] prevState [ND];
  logic         outValid  [ND];
  logic         outReady  [ND];
  logic [127:0] nextState [ND];
  logic         busy      [ND];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sb_f [256];
  logic [7:0]   sb_i [256];
  bit           m_pend [ND];
  int           m_age  [ND];
  logic [127:0] m_exp  [ND];
  logic [127:0] m_last [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    sub_bytes_seq #(.LANES(LN[g]), .INV_EN(IE[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inValid   (inValid[g]),
      .inReady   (inReady[g]),
      .inMode    (inMode[g]),
      .prevState (prevState[g]),
      .outValid  (outValid[g]),
      .outReady  (outReady[g]),
      .nextState (nextState[g]),
      .busy      (busy[g])
    );
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    return 8'((v << k) | (v >> (8 - k)));
  endfunction

  function automatic logic [127:0] model_sub(input logic [127:0] s, input bit inv);
    logic [127:0] r = '0;
    for (int b = 0; b < 16; b++)
      r[127-8*b -: 8] = inv ? sb_i[s[127-8*b -: 8]] : sb_f[s[127-8*b -: 8]];
    return r;
  endfunction

  // Per-cycle compare: expectations come from accept time, BEATS and the substituted state.
  bit ev, er;
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        check($sformatf("d%0d_rst_outValid", d), outValid[d], 0);
        check($sformatf("d%0d_rst_inReady", d), inReady[d], 1);
        check($sformatf("d%0d_rst_busy", d), busy[d], 0);
        check($sformatf("d%0d_rst_nextState", d), nextState[d], 0);
        m_pend[d] = 1'b0;
        m_age[d]  = 0;
        m_last[d] = '0;
      end else begin
        ev = m_pend[d] && (m_age[d] >= 16 / LN[d]);
        er = !m_pend[d] || (ev && outReady[d]);
        check($sformatf("d%0d_outValid", d), outValid[d], ev);
        check($sformatf("d%0d_inReady", d), inReady[d], er);
        check($sformatf("d%0d_busy", d), busy[d], m_pend[d]);
        if (ev) check($sformatf("d%0d_nextState", d), nextState[d], m_exp[d]);
        else if (!m_pend[d]) check($sformatf("d%0d_idle_state", d), nextState[d], m_last[d]);
        if (ev && outReady[d]) begin
          m_pend[d] = 1'b0;
          m_last[d] = m_exp[d];
        end
        if (inValid[d] && er) begin
          m_pend[d] = 1'b1;
          m_age[d]  = 0;
          m_exp[d]  = model_sub(prevState[d], inMode[d] && IE[d]);
        end else if (m_pend[d]) begin
          m_age[d]++;
        end
      end
    end
  end

  task automatic send(input int d, input logic [127:0] s, input logic m);
    int n = 0;
    @(posedge clk); #1;
    inValid[d] = 1'b1; prevState[d] = s; inMode[d] = m;
    @(negedge clk);
    while (!inReady[d] && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) check($sformatf("d%0d_send_timeout", d), n, 0);
    @(posedge clk); #1;
    inValid[d] = 1'b0;
    prevState[d] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(input int d, input logic [127:0] exp, input string name);
    int n = 0;
    @(negedge clk);
    while (!outValid[d] && n < 200) begin n++; @(negedge clk); end
    check({name, "_latency"}, n, 16 / LN[d]);
    check({name, "_data"}, nextState[d], exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < ND; d++) begin
      inValid[d] = 1'b0; inMode[d] = 1'b0; prevState[d] = '0; outReady[d] = 1'b1;
    end
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv, b;
      iv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      b = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
      sb_f[x] = b;
      sb_i[b] = 8'(x);
    end
    check("model_S00", sb_f[8'h00], 8'h63);
    check("model_S7d", sb_f[8'h7d], 8'hff);
    check("model_S20", sb_f[8'h20], 8'hb7);
    check("model_Si63", sb_i[8'h63], 8'h00);
    check("model_round1", model_sub(T1_IN, 1'b0), T1_OUT);
    check("model_corner", model_sub(CORN_IN, 1'b0), CORN_OUT);

    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;

    send(0, T1_IN, 1'b0);
    wait_out(0, T1_OUT, "t1_fwd_l4");
    send(0, T1_OUT, 1'b1);
    wait_out(0, T1_IN, "t2_inv_l4");
    send(1, CORN_IN, 1'b0);
    wait_out(1, CORN_OUT, "t3_corner_l16");

    @(posedge clk); #1 outReady[2] = 1'b0;
    send(2, CORN_IN, 1'b0);
    wait_out(2, CORN_OUT, "t4_first_l2");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_data", nextState[2], CORN_OUT);
      check("t4_hold_inReady", inReady[2], 0);
      check("t4_hold_outValid", outValid[2], 1);
    end
    @(posedge clk); #1;
    outReady[2] = 1'b1; inValid[2] = 1'b1; prevState[2] = T1_IN; inMode[2] = 1'b0;
    @(negedge clk);
    check("t4_b2b_inReady", inReady[2], 1);
    @(posedge clk); #1 inValid[2] = 1'b0;
    wait_out(2, T1_OUT, "t4_second_l2");

    send(3, CORN_IN, 1'b0);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_async_outValid", outValid[3], 0);
    check("t5_async_nextState", nextState[3], 0);
    check("t5_async_inReady", inReady[3], 1);
    check("t5_async_busy", busy[3], 0);
    @(negedge clk); #2 rst_n = 1'b1;
    send(3, T1_IN, 1'b0);
    wait_out(3, T1_OUT, "t5_after_rst_l1");

    send(4, 128'h0, 1'b1);
    wait_out(4, {16{8'h63}}, "t6_inv_disabled");

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) begin
        inValid[d]   = 1'($urandom_range(0, 1));
        inMode[d]    = 1'($urandom_range(0, 1));
        prevState[d] = {$urandom, $urandom, $urandom, $urandom};
        outReady[d]  = ($urandom_range(0, 3) != 0);
      end
    end
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) begin
      inValid[d] = 1'b0; outReady[d] = 1'b1;
    end
    repeat (20) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
